// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for inter-stage pipeline registers: hazard-control encodings,
// stage payload layout and per-stage bubble constants.
package pipe_stage_skid_pkg;

  localparam int CTRL_W = 2;
  localparam logic [CTRL_W-1:0] CTRL_STATE_DEFAULT = 2'b00;
  localparam logic [CTRL_W-1:0] CTRL_STATE_STALLED = 2'b01;
  localparam logic [CTRL_W-1:0] CTRL_STATE_BUBBLE  = 2'b10;

  localparam int PL_WREG_OFF      = 0;
  localparam int PL_CSR_WREG_OFF  = 1;
  localparam int PL_RD_ADDR_OFF   = 2;
  localparam int PL_RD_ADDR_W     = 5;
  localparam int PL_CSR_WADDR_OFF = PL_RD_ADDR_OFF + PL_RD_ADDR_W;
  localparam int PL_CSR_WADDR_W   = 12;
  localparam int PL_WDATA_OFF     = PL_CSR_WADDR_OFF + PL_CSR_WADDR_W;
  localparam int PL_WDATA_W       = 64;
  localparam int PL_CSR_WDATA_OFF = PL_WDATA_OFF + PL_WDATA_W;
  localparam int PL_CSR_WDATA_W   = 64;
  localparam int PL_W             = PL_CSR_WDATA_OFF + PL_CSR_WDATA_W;

  localparam logic [11:0] CSR_ADDR_MARCHID = 12'hF12;
  localparam logic [4:0]  REG_ZERO         = 5'd0;

  function automatic logic [PL_W-1:0] pack_payload(
    input logic [4:0]  rd_addr,
    input logic [11:0] csr_waddr,
    input logic        wreg,
    input logic        csr_wreg,
    input logic [63:0] wdata,
    input logic [63:0] csr_wdata
  );
    return {csr_wdata, wdata, csr_waddr, rd_addr, csr_wreg, wreg};
  endfunction

  // A bubble must never write the register file or a CSR.
  localparam logic [PL_W-1:0] EX_MEM_BUBBLE =
    pack_payload(REG_ZERO, CSR_ADDR_MARCHID, 1'b0, 1'b0, 64'd0, 64'd0);

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter with synchronous clear that overrides a same-cycle increment.
module sat_counter
  import pipe_stage_skid_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional 2-entry skid,
// hazard-unit stall/bubble/flush control and saturating stall/bubble counters.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int              DATA_W     = PL_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter bit              SKID_EN    = 1'b1,
  parameter int              CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_signal_i,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic              rdy_q, rdy_d;
  logic              is_default, is_stalled, is_bubble;
  logic              up_ready, xfer_up, xfer_dn;

  // Flush outranks every ctrl code; unknown codes fall through to bubble.
  assign is_stalled = !flush_i && (ctrl_signal_i == CTRL_STATE_STALLED);
  assign is_default = !flush_i && (ctrl_signal_i == CTRL_STATE_DEFAULT);
  assign is_bubble  = !flush_i && !is_stalled && !is_default;

  always_comb begin
    if (SKID_EN) up_ready = rdy_q & is_default;
    else         up_ready = (~main_vld_q | dn_ready_i) & is_default;
  end

  assign xfer_up = up_valid_i & up_ready;
  assign xfer_dn = main_vld_q & dn_ready_i & is_default;

  always_comb begin
    main_data_d = main_data_q;
    main_vld_d  = main_vld_q;
    skid_data_d = skid_data_q;
    skid_vld_d  = skid_vld_q;
    if (flush_i) begin
      main_data_d = BUBBLE_VAL;
      main_vld_d  = 1'b0;
      skid_data_d = BUBBLE_VAL;
      skid_vld_d  = 1'b0;
    end else if (is_bubble) begin
      main_data_d = BUBBLE_VAL;
      main_vld_d  = 1'b0;
    end else if (is_default) begin
      if (!main_vld_q || xfer_dn) begin
        if (skid_vld_q) begin
          // Oldest entry lives in the skid; promote it before anything newer.
          main_data_d = skid_data_q;
          main_vld_d  = 1'b1;
          skid_vld_d  = xfer_up;
          if (xfer_up) skid_data_d = up_data_i;
        end else if (xfer_up) begin
          main_data_d = up_data_i;
          main_vld_d  = 1'b1;
        end else begin
          main_vld_d  = 1'b0;
        end
      end else if (xfer_up && SKID_EN) begin
        skid_data_d = up_data_i;
        skid_vld_d  = 1'b1;
      end
    end
    rdy_d = ~skid_vld_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_data_q <= BUBBLE_VAL;
      main_vld_q  <= 1'b0;
      skid_data_q <= BUBBLE_VAL;
      skid_vld_q  <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      main_data_q <= main_data_d;
      main_vld_q  <= main_vld_d;
      skid_data_q <= skid_data_d;
      skid_vld_q  <= skid_vld_d;
      rdy_q       <= rdy_d;
    end
  end

  assign up_ready_o = up_ready;
  assign dn_valid_o = main_vld_q;
  assign dn_data_o  = main_data_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (is_stalled),
    .clr_i (cnt_clr_i),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush_i | is_bubble),
    .clr_i (cnt_clr_i),
    .cnt_o (bubble_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: an ordered-queue reference model drives expectations,
// a negedge monitor compares handshake state, counters and every downstream transfer.
module tb_pipe_stage_skid;
  import pipe_stage_skid_pkg::*;

  localparam int              DW   = 16;
  localparam logic [DW-1:0]   BV   = 16'hBEEF;
  localparam int              CW   = 4;
  localparam int              CMAX = (1 << CW) - 1;
  localparam logic [1:0] DEF = CTRL_STATE_DEFAULT;
  localparam logic [1:0] STL = CTRL_STATE_STALLED;
  localparam logic [1:0] BUB = CTRL_STATE_BUBBLE;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CTRL_W-1:0] ctrl_signal_i = DEF;
  logic              flush_i = 1'b0;
  logic              up_valid_i = 1'b0;
  logic              up_ready_o;
  logic [DW-1:0]     up_data_i = '0;
  logic              dn_valid_o;
  logic              dn_ready_i = 1'b0;
  logic [DW-1:0]     dn_data_o;
  logic              cnt_clr_i = 1'b0;
  logic [CW-1:0]     stall_cnt_o;
  logic [CW-1:0]     bubble_cnt_o;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .BUBBLE_VAL(BV), .SKID_EN(1'b1), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .ctrl_signal_i (ctrl_signal_i),
    .flush_i       (flush_i),
    .up_valid_i    (up_valid_i),
    .up_ready_o    (up_ready_o),
    .up_data_i     (up_data_i),
    .dn_valid_o    (dn_valid_o),
    .dn_ready_i    (dn_ready_i),
    .dn_data_o     (dn_data_o),
    .cnt_clr_i     (cnt_clr_i),
    .stall_cnt_o   (stall_cnt_o),
    .bubble_cnt_o  (bubble_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: ordered list of held payloads; the head is shown downstream when presented.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] sb_q[$];
  bit presented = 0, clean = 1, rdy_armed = 0;
  int m_stall = 0, m_bub = 0;

  bit            mon_en = 0;
  bit            e_vld, e_rdy, e_clean;
  logic [DW-1:0] e_data;
  int            e_stall, e_bub;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v == CMAX) ? v : v + 1;
  endfunction

  task automatic step(input logic [1:0] c, input bit f, input bit uv, input logic [DW-1:0] ud,
                      input bit dr, input bit clr);
    @(posedge clk); #1;
    rdy_armed     = 1;
    ctrl_signal_i = c;
    flush_i       = f;
    up_valid_i    = uv;
    up_data_i     = ud;
    dn_ready_i    = dr;
    cnt_clr_i     = clr;
    e_vld   = presented;
    e_data  = presented ? mq[0] : BV;
    e_clean = presented || clean;
    e_rdy   = rdy_armed && (c == DEF) && !f && (mq.size() == int'(presented));
    e_stall = m_stall;
    e_bub   = m_bub;
    if (f) begin
      mq.delete();
      presented = 0;
      clean     = 1;
      m_bub     = sat_inc(m_bub);
    end else if (c == STL) begin
      m_stall = sat_inc(m_stall);
    end else if (c == DEF) begin
      if (presented && dr) sb_q.push_back(mq.pop_front());
      if (uv && e_rdy) mq.push_back(ud);
      presented = (mq.size() > 0);
      if (presented) clean = 0;
    end else begin
      if (presented) void'(mq.pop_front());
      presented = 0;
      clean     = 1;
      m_bub     = sat_inc(m_bub);
    end
    if (clr) begin
      m_stall = 0;
      m_bub   = 0;
    end
  endtask

  task automatic idle(input bit dr);
    step(DEF, 1'b0, 1'b0, '0, dr, 1'b0);
  endtask

  task automatic push(input logic [DW-1:0] d, input bit dr);
    step(DEF, 1'b0, 1'b1, d, dr, 1'b0);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // Reset is asserted between clock edges so the asynchronous path is exercised.
  task automatic apply_reset();
    @(posedge clk); #3;
    rst = 1'b0;
    ctrl_signal_i = DEF; flush_i = 0; up_valid_i = 0; dn_ready_i = 0; cnt_clr_i = 0;
    mq.delete(); sb_q.delete();
    presented = 0; clean = 1; rdy_armed = 0; m_stall = 0; m_bub = 0;
    e_vld = 0; e_clean = 1; e_data = BV; e_rdy = 0; e_stall = 0; e_bub = 0;
    mon_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("dn_valid", dn_valid_o, e_vld);
      if (e_clean) chk("dn_data", dn_data_o, e_data);
      chk("up_ready", up_ready_o, e_rdy);
      chk("stall_cnt", stall_cnt_o, e_stall);
      chk("bubble_cnt", bubble_cnt_o, e_bub);
      if (rst && dn_valid_o && dn_ready_i && ctrl_signal_i == DEF && !flush_i) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%0h expected no transfer at %0t", dn_data_o, $time);
        end else begin
          chk("dn_payload", dn_data_o, sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();

    // Streaming at full rate.
    for (int i = 0; i < 8; i++) push(DW'(16'h11 + i), 1'b1);
    idle(1'b1); idle(1'b1);

    // Backpressure fills the skid.
    push(16'hA1, 1'b0);
    push(16'hA2, 1'b0);
    idle(1'b0);
    settle();
    chk("bp_up_ready_full", up_ready_o, 0);
    chk("bp_head_A1", dn_data_o, 16'hA1);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Stall holding B5.
    push(16'hB5, 1'b0);
    step(DEF, 0, 0, '0, 0, 1);
    for (int i = 0; i < 3; i++) step(STL, 0, 1, 16'h5555, 1, 0);
    idle(1'b0);
    settle();
    chk("stall_cnt_3", stall_cnt_o, 3);
    chk("stall_held_B5", dn_data_o, 16'hB5);

    // Bubble then flush with skid full.
    step(DEF, 0, 0, '0, 0, 1);
    step(BUB, 0, 0, '0, 0, 0);
    idle(1'b0);
    settle();
    chk("bubble_dn_valid", dn_valid_o, 0);
    chk("bubble_dn_data", dn_data_o, BV);
    push(16'hC1, 1'b0);
    push(16'hC2, 1'b0);
    step(DEF, 1, 1, 16'hC3, 1, 0);
    idle(1'b0);
    settle();
    chk("flush_bubble_cnt_2", bubble_cnt_o, 2);
    chk("flush_dn_valid", dn_valid_o, 0);
    push(16'hD1, 1'b0);
    step(STL, 1, 0, '0, 0, 0);
    idle(1'b0);
    settle();
    chk("flush_over_stall_valid", dn_valid_o, 0);
    chk("flush_over_stall_cnt", stall_cnt_o, 0);

    // Counter saturation and clear-over-increment.
    step(DEF, 0, 0, '0, 0, 1);
    for (int i = 0; i < 20; i++) step(STL, 0, 0, '0, 0, 0);
    idle(1'b0);
    settle();
    chk("stall_cnt_saturated", stall_cnt_o, CMAX);
    step(STL, 0, 0, '0, 0, 1);
    idle(1'b0);
    settle();
    chk("stall_cnt_clr_wins", stall_cnt_o, 0);

    // Reset with two entries held.
    push(16'hE1, 1'b0);
    push(16'hE2, 1'b0);
    apply_reset();
    chk("reset_dn_valid", dn_valid_o, 0);
    chk("reset_dn_data", dn_data_o, BV);
    chk("reset_bubble_cnt", bubble_cnt_o, 0);

    // Randomized traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 500; i++) begin
      int r;
      logic [1:0] c;
      if (i == 250) apply_reset();
      r = $urandom_range(0, 99);
      c = (r < 80) ? DEF : (r < 90) ? STL : (r < 97) ? BUB : 2'b11;
      step(c, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 70, DW'($urandom),
           $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 3);
    end

    for (int i = 0; i < 4; i++) idle(1'b1);
    settle();
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("drained_dn_valid", dn_valid_o, 0);

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
